// File: rtl/pipe_out_block_buffer_pkg.sv
// Shared types and constants for the PipeOut block buffer.
// Holds the FSM state enum, default sizes and the saturating-counter helper.
package pipe_out_block_buffer_pkg;

  localparam int unsigned PIPE_DATA_W     = 32;
  localparam int unsigned DEF_DEPTH_LOG2  = 10;
  localparam int unsigned DEF_BLOCK_WORDS = 256;
  localparam int unsigned CNT_W           = 16;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_e;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/pipe_out_block_buffer_sync_fifo_regout.sv
// Single-clock FIFO with registered read data and an occupancy count.
// Storage has no reset so it can map onto block RAM; only pointers and flags reset.
module sync_fifo_regout #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  output logic                  wr_ready,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic                  rd_en,
  output logic [DATA_W-1:0]     rd_data,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  empty_c
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned LVL_W = DEPTH_LOG2 + 1;

  logic [DATA_W-1:0]     mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [LVL_W-1:0]      level_nxt;
  logic                  push_c;
  logic                  pop_c;

  assign empty_c = (level == '0);
  assign push_c  = wr_en && wr_ready;
  assign pop_c   = rd_en && !empty_c;

  always_comb begin
    level_nxt = level;
    case ({push_c, pop_c})
      2'b10:   level_nxt = level + LVL_W'(1);
      2'b01:   level_nxt = level - LVL_W'(1);
      default: level_nxt = level;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push_c) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // wr_ready is registered from the next level so it equals (level < DEPTH) after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      wr_ready <= 1'b0;
      rd_data  <= '0;
    end else begin
      if (push_c) begin
        wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
      end
      if (pop_c) begin
        rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
      end
      if (rd_en) begin
        rd_data <= pop_c ? mem[rd_ptr] : '0;
      end
      level    <= level_nxt;
      wr_ready <= (level_nxt < LVL_W'(DEPTH));
    end
  end

endmodule

// File: rtl/pipe_out_block_buffer.sv
// Elastic block buffer feeding a block-throttled PipeOut endpoint.
// Advertises ready only with a full block buffered and counts host protocol violations.
module pipe_out_block_buffer
  import pipe_out_block_buffer_pkg::*;
#(
  parameter int unsigned DATA_W      = PIPE_DATA_W,
  parameter int unsigned DEPTH_LOG2  = DEF_DEPTH_LOG2,
  parameter int unsigned BLOCK_WORDS = DEF_BLOCK_WORDS
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic [DATA_W-1:0]   s_data,
  input  logic                pipe_out_read,
  input  logic                pipe_out_blockstrobe,
  output logic [DATA_W-1:0]   pipe_out_data,
  output logic                pipe_out_ready,
  output logic [DEPTH_LOG2:0] level,
  output logic [CNT_W-1:0]    underrun_count,
  output logic [CNT_W-1:0]    stray_read_count
);

  localparam int unsigned      LVL_W     = DEPTH_LOG2 + 1;
  localparam logic [LVL_W-1:0] BLOCK_LVL = LVL_W'(BLOCK_WORDS);

  state_e           state;
  state_e           state_nxt;
  logic [LVL_W-1:0] remaining;
  logic [LVL_W-1:0] remaining_nxt;
  logic             ready_nxt;
  logic [CNT_W-1:0] underrun_nxt;
  logic [CNT_W-1:0] stray_nxt;
  logic             fifo_empty_c;

  sync_fifo_regout #(
    .DATA_W     (DATA_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (s_valid),
    .wr_ready (s_ready),
    .wr_data  (s_data),
    .rd_en    (pipe_out_read),
    .rd_data  (pipe_out_data),
    .level    (level),
    .empty_c  (fifo_empty_c)
  );

  // Next state, burst countdown, ready advertisement and violation counters.
  always_comb begin
    state_nxt     = state;
    remaining_nxt = remaining;
    ready_nxt     = 1'b0;
    underrun_nxt  = underrun_count;
    stray_nxt     = stray_read_count;
    case (state)
      ST_IDLE: begin
        if (pipe_out_blockstrobe && pipe_out_ready) begin
          state_nxt     = ST_BURST;
          remaining_nxt = BLOCK_LVL;
        end else begin
          ready_nxt = (level >= BLOCK_LVL);
        end
        if (pipe_out_read && !fifo_empty_c) begin
          stray_nxt = sat_inc(stray_read_count);
        end
      end
      ST_BURST: begin
        // Every read consumes a slot of the block, even one that underruns.
        if (pipe_out_read) begin
          remaining_nxt = remaining - LVL_W'(1);
          if (remaining == LVL_W'(1)) begin
            state_nxt = ST_IDLE;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
    if (pipe_out_read && fifo_empty_c) begin
      underrun_nxt = sat_inc(underrun_count);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= ST_IDLE;
      remaining        <= '0;
      pipe_out_ready   <= 1'b0;
      underrun_count   <= '0;
      stray_read_count <= '0;
    end else begin
      state            <= state_nxt;
      remaining        <= remaining_nxt;
      pipe_out_ready   <= ready_nxt;
      underrun_count   <= underrun_nxt;
      stray_read_count <= stray_nxt;
    end
  end

endmodule

// File: tb/tb_pipe_out_block_buffer.sv
// Directed bench for pipe_out_block_buffer with a 4-word block and 8-word FIFO.
module tb_pipe_out_block_buffer;
  import pipe_out_block_buffer_pkg::*;

  logic        clk;
  logic        reset;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] s_data;
  logic        pipe_out_read;
  logic        pipe_out_blockstrobe;
  logic [31:0] pipe_out_data;
  logic        pipe_out_ready;
  logic [3:0]  level;
  logic [15:0] underrun_count;
  logic [15:0] stray_read_count;

  int checks   = 0;
  int failures = 0;

  pipe_out_block_buffer #(
    .DATA_W      (32),
    .DEPTH_LOG2  (3),
    .BLOCK_WORDS (4)
  ) dut (
    .clk                  (clk),
    .reset                (reset),
    .s_valid              (s_valid),
    .s_ready              (s_ready),
    .s_data               (s_data),
    .pipe_out_read        (pipe_out_read),
    .pipe_out_blockstrobe (pipe_out_blockstrobe),
    .pipe_out_data        (pipe_out_data),
    .pipe_out_ready       (pipe_out_ready),
    .level                (level),
    .underrun_count       (underrun_count),
    .stray_read_count     (stray_read_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] d);
    s_valid = 1'b1;
    s_data  = d;
    step();
    s_valid = 1'b0;
  endtask

  // Strobe then four back-to-back reads, checking each returned word.
  task automatic do_burst(input logic [31:0] e0, input logic [31:0] e1,
                          input logic [31:0] e2, input logic [31:0] e3);
    logic [31:0] exp_w [4];
    exp_w[0] = e0; exp_w[1] = e1; exp_w[2] = e2; exp_w[3] = e3;
    pipe_out_blockstrobe = 1'b1;
    step();
    pipe_out_blockstrobe = 1'b0;
    chk("burst_ready_low", 32'(pipe_out_ready), 32'd0);
    pipe_out_read = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("burst_data", pipe_out_data, exp_w[i]);
      chk("burst_ready", 32'(pipe_out_ready), 32'd0);
    end
    pipe_out_read = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    s_valid = 1'b0;
    s_data = '0;
    pipe_out_read = 1'b0;
    pipe_out_blockstrobe = 1'b0;
    step();
    step();
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_ready", 32'(pipe_out_ready), 32'd0);
    chk("rst_data", pipe_out_data, 32'd0);
    chk("rst_sready", 32'(s_ready), 32'd0);
    chk("rst_underrun", 32'(underrun_count), 32'd0);
    chk("rst_stray", 32'(stray_read_count), 32'd0);
    reset = 1'b0;
    step();
    chk("post_rst_sready", 32'(s_ready), 32'd1);

    // Scenario 1: ready only once a full block sits in the FIFO
    push(32'h11);
    push(32'h22);
    push(32'h33);
    step();
    chk("s1_level3", 32'(level), 32'd3);
    chk("s1_ready_at3", 32'(pipe_out_ready), 32'd0);
    push(32'h44);
    chk("s1_level4", 32'(level), 32'd4);
    chk("s1_ready_lag", 32'(pipe_out_ready), 32'd0);
    step();
    chk("s1_ready_up", 32'(pipe_out_ready), 32'd1);

    // Scenario 2: in-spec burst
    do_burst(32'h11, 32'h22, 32'h33, 32'h44);
    chk("s2_level", 32'(level), 32'd0);
    step();
    chk("s2_ready_after", 32'(pipe_out_ready), 32'd0);
    chk("s2_underrun", 32'(underrun_count), 32'd0);
    chk("s2_stray", 32'(stray_read_count), 32'd0);

    // Scenario 3: fill to full, producer holds a ninth word
    s_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      s_data = 32'h100 + 32'(i);
      step();
    end
    chk("s3_level_full", 32'(level), 32'd8);
    chk("s3_sready_full", 32'(s_ready), 32'd0);
    s_data = 32'h999;
    step();
    chk("s3_level_held", 32'(level), 32'd8);
    chk("s3_ready", 32'(pipe_out_ready), 32'd1);
    pipe_out_blockstrobe = 1'b1;
    step();
    pipe_out_blockstrobe = 1'b0;
    pipe_out_read = 1'b1;
    step();
    chk("s3_d0", pipe_out_data, 32'h100);
    chk("s3_lvl_r1", 32'(level), 32'd7);
    chk("s3_sready_r1", 32'(s_ready), 32'd1);
    step();
    s_valid = 1'b0;
    chk("s3_d1", pipe_out_data, 32'h101);
    chk("s3_lvl_r2", 32'(level), 32'd7);
    step();
    chk("s3_d2", pipe_out_data, 32'h102);
    step();
    pipe_out_read = 1'b0;
    chk("s3_d3", pipe_out_data, 32'h103);
    chk("s3_level5", 32'(level), 32'd5);
    step();
    chk("s3_ready_again", 32'(pipe_out_ready), 32'd1);
    do_burst(32'h104, 32'h105, 32'h106, 32'h107);
    chk("s3_level1", 32'(level), 32'd1);
    push(32'hA1);
    push(32'hA2);
    push(32'hA3);
    step();
    chk("s3_ready_held", 32'(pipe_out_ready), 32'd1);
    do_burst(32'h999, 32'hA1, 32'hA2, 32'hA3);
    chk("s3_level0", 32'(level), 32'd0);

    // Scenario 4: underrun read, then stray read in IDLE
    pipe_out_read = 1'b1;
    step();
    pipe_out_read = 1'b0;
    chk("s4_data_zero", pipe_out_data, 32'd0);
    chk("s4_underrun", 32'(underrun_count), 32'd1);
    chk("s4_level0", 32'(level), 32'd0);
    chk("s4_stray0", 32'(stray_read_count), 32'd0);
    push(32'h55);
    push(32'h66);
    chk("s4_level2", 32'(level), 32'd2);
    pipe_out_read = 1'b1;
    step();
    pipe_out_read = 1'b0;
    chk("s4_stray_data", pipe_out_data, 32'h55);
    chk("s4_level1", 32'(level), 32'd1);
    chk("s4_stray1", 32'(stray_read_count), 32'd1);
    chk("s4_underrun1", 32'(underrun_count), 32'd1);
    step();
    chk("s4_data_hold", pipe_out_data, 32'h55);

    // Scenario 5: concurrent push during a burst keeps level steady
    push(32'h77);
    push(32'h88);
    push(32'h99);
    step();
    chk("s5_ready", 32'(pipe_out_ready), 32'd1);
    pipe_out_blockstrobe = 1'b1;
    step();
    pipe_out_blockstrobe = 1'b0;
    pipe_out_read = 1'b1;
    s_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      s_data = 32'hB0 + 32'(i);
      step();
      chk("s5_level", 32'(level), 32'd4);
      chk("s5_ready_low", 32'(pipe_out_ready), 32'd0);
    end
    chk("s5_last_data", pipe_out_data, 32'h99);
    pipe_out_read = 1'b0;
    s_valid = 1'b0;
    step();
    chk("s5_ready_back", 32'(pipe_out_ready), 32'd1);
    chk("s5_stray", 32'(stray_read_count), 32'd1);

    // Scenario 6: reset mid-burst discards everything
    pipe_out_blockstrobe = 1'b1;
    step();
    pipe_out_blockstrobe = 1'b0;
    pipe_out_read = 1'b1;
    step();
    chk("s6_d0", pipe_out_data, 32'hB0);
    step();
    chk("s6_d1", pipe_out_data, 32'hB1);
    pipe_out_read = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("s6_level", 32'(level), 32'd0);
    chk("s6_ready", 32'(pipe_out_ready), 32'd0);
    chk("s6_data", pipe_out_data, 32'd0);
    chk("s6_fsm", 32'(dut.state), 32'(ST_IDLE));
    chk("s6_underrun", 32'(underrun_count), 32'd0);
    chk("s6_stray", 32'(stray_read_count), 32'd0);
    chk("s6_sready_rst", 32'(s_ready), 32'd0);
    step();
    chk("s6_sready", 32'(s_ready), 32'd1);
    push(32'hC1);
    push(32'hC2);
    push(32'hC3);
    push(32'hC4);
    step();
    chk("s6_ready_up", 32'(pipe_out_ready), 32'd1);
    do_burst(32'hC1, 32'hC2, 32'hC3, 32'hC4);
    chk("s6_level_end", 32'(level), 32'd0);
    chk("s6_underrun_end", 32'(underrun_count), 32'd0);
    chk("s6_stray_end", 32'(stray_read_count), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_out_block_buffer.md
Name: pipe_out_block_buffer

Overview:
- Elastic block buffer between a word producer (e.g. a pattern generator or capture path) and the block-throttled PipeOut endpoint on okClk.
- Accepts a 32-bit valid/ready stream and stores it in an internal FIFO.
- Advertises pipe_out_ready only when one full block is buffered, then serves that block with registered-read timing.
- Counts protocol violations (underruns, stray reads) for host readback through a WireOut.

Parameters:
- DATA_W, 32, word width.
- DEPTH_LOG2, 10, FIFO depth = 2^DEPTH_LOG2 words.
- BLOCK_WORDS, 256, words per PipeOut block; 1 <= BLOCK_WORDS <= 2^DEPTH_LOG2.

Ports:
- clk  in  1  okClk domain clock.
- reset  in  1  synchronous, active-high reset.
- s_valid  in  1  producer word valid.
- s_ready  out  1  buffer can accept a word.
- s_data  in  DATA_W  producer word.
- pipe_out_read  in  1  endpoint read strobe, one word per cycle.
- pipe_out_blockstrobe  in  1  endpoint pulse, one cycle before the first read of a block.
- pipe_out_data  out  DATA_W  word returned for a read.
- pipe_out_ready  out  1  a full block is available.
- level  out  DEPTH_LOG2+1  current FIFO occupancy.
- underrun_count  out  16  reads while empty; saturating.
- stray_read_count  out  16  reads outside BURST; saturating.

Behaviour:
- Reset (synchronous, active-high) values:
  - FIFO emptied, level=0, FSM=IDLE.
  - s_ready=0 on the reset cycle, 1 from the next cycle.
  - pipe_out_ready=0, pipe_out_data=0.
  - Both counters=0.
  - Reset mid-burst discards all data and abandons the block; no flush.
- Write side:
  - Push when s_valid && s_ready.
  - s_ready = (level < 2^DEPTH_LOG2).
  - At full, s_ready=0; the producer must hold its word. No drop and no overflow is possible.
- Read side:
  - A pop occurs on a cycle with pipe_out_read=1 and level>0.
  - pipe_out_data is registered and valid the cycle after pipe_out_read.
  - pipe_out_data holds its value otherwise.
  - Read while level=0: no pop, pipe_out_data<=0, underrun_count increments (saturates at 16'hFFFF).
- Simultaneous push and pop: level unchanged. Pushes into an empty FIFO are readable from the following cycle; no same-cycle bypass.
- Level arithmetic: level width DEPTH_LOG2+1. Pointers are DEPTH_LOG2 bits and wrap modulo depth; full/empty are determined from level.
- FSM:
  - IDLE: pipe_out_ready = (level >= BLOCK_WORDS), registered from the current level.
    - pipe_out_blockstrobe while pipe_out_ready=1 -> BURST, with remaining<=BLOCK_WORDS.
    - Strobe while not ready -> stay in IDLE (host violation, not counted).
  - BURST: pipe_out_ready=0.
    - Each pipe_out_read decrements remaining, whether or not it pops.
    - remaining reaching 0 -> IDLE on the next cycle; ready re-evaluates the cycle after.
    - Strobe during BURST is ignored.
  - A read in IDLE still pops if level>0 and increments stray_read_count (saturating).
- Because ready is asserted only with >= BLOCK_WORDS buffered and the producer cannot steal words, an in-spec burst never underruns.
- Latency:
  - Producer word to visibility in level: 1 cycle.
  - Level crossing BLOCK_WORDS to pipe_out_ready=1: 1 cycle.

Decomposition:
- Shared package holds:
  - PIPE_DATA_W=32.
  - Default block size constant.
  - FSM state enum {IDLE, BURST}.
  - Counter width constant CNT_W=16.
- One natural sub-module: sync_fifo_regout.
  - Single-clock FIFO, registered read data, level output, full/empty flags.
  - Maps to block RAM.
  - Top module holds the FSM, the remaining counter and the violation counters.

Test Plan:
- Bench uses BLOCK_WORDS=4, DEPTH_LOG2=3.
- Scenario 1: reset, then push 3 words -> pipe_out_ready stays 0, level=3. Push a 4th -> pipe_out_ready=1 one cycle after level=4.
- Scenario 2: push 0x11..0x44, strobe, then 4 consecutive reads -> pipe_out_data = 0x11, 0x22, 0x33, 0x44 on the cycles after each read. pipe_out_ready=0 during the burst, level=0 at the end, both counters=0.
- Scenario 3: push 8 words with s_valid held high -> s_ready=0 at level=8. A 9th word is held and not lost. After a 4-word burst, the held word is accepted and level=5.
- Scenario 4: read with an empty FIFO -> pipe_out_data=0, underrun_count=1, level stays 0. Read in IDLE with level=2 -> pop occurs and stray_read_count=1.
- Scenario 5: concurrent push every cycle during a 4-word burst starting at level=4 -> level stays 4, FSM returns to IDLE, pipe_out_ready reasserts.
- Scenario 6: assert reset after 2 reads of a burst -> next cycle level=0, pipe_out_ready=0, FSM=IDLE, counters=0. A subsequent full block transfers correctly.
